bcd_score_display: RTL and testbench

- Parametrised multi-digit BCD point counter with registered 7-segment outputs; next-generation score display for the Whack game.
- Accepts hit/miss events with a variable point value from game memory and keeps a saturating BCD score plus a session high score.
- Drives DIGITS active-low 7-segment displays (HEX4, HEX5, ...) directly.

---
 rtl/score_pkg.sv | 16 +
 rtl/bcd_seg_decoder.sv | 24 ++
 rtl/bcd_score_display.sv | 87 ++++++++
 tb/tb_bcd_score_display.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// score_pkg: shared BCD digit type, 7-segment codes and digit limit for the score display
package score_pkg;
  typedef logic [3:0] bcd_t;
  localparam bcd_t BCD_MAX_DIGIT = 4'd9;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
endpackage

// File: rtl/bcd_seg_decoder.sv
// bcd_seg_decoder: one BCD digit to active-low {g..a} segments; non-BCD codes show blank
module bcd_seg_decoder
  import score_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  // digit lookup, anything above 9 blanks the display
  always_comb begin
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end
endmodule

// File: rtl/bcd_score_display.sv
// bcd_score_display: saturating BCD score and high score with registered 7-segment outputs.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN blanks leading zero digits above digit 0.
module bcd_score_display
  import score_pkg::*;
#(
  parameter int DIGITS       = 2,
  parameter int MISS_PENALTY = 1
) (
  input  logic                  Clock,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  hit,
  input  logic                  miss,
  input  logic [3:0]            points,
  output logic [4*DIGITS-1:0]   score_bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [7*DIGITS-1:0]   seg,
  output logic                  new_high,
  output logic                  saturated
);
  localparam int W = 4 * DIGITS;
  localparam logic [W-1:0] ALL_NINE = {DIGITS{BCD_MAX_DIGIT}};
`ifdef SCORE_LEADING_ZERO_BLANK_EN
  localparam logic [7*DIGITS-1:0] SEG_RESET = {DIGITS{SEG_BLANK}} ^ (7*DIGITS)'(SEG_BLANK ^ SEG_0);
`else
  localparam logic [7*DIGITS-1:0] SEG_RESET = {DIGITS{SEG_0}};
`endif
  logic [W-1:0] add_sum, sub_diff, score_next;
  logic [3:0] add_carry, sub_borrow, ddiff;
  logic [4:0] dsum;
  logic lt;
  logic [7*DIGITS-1:0] seg_raw, seg_next;
  // digit-serial add of the clamped hit value; the first carry-in is the points themselves
  always_comb begin
    add_carry = (points > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : points;
    add_sum = '0;
    dsum = '0;
    for (int i = 0; i < DIGITS; i++) begin
      dsum = {1'b0, score_bcd[4*i+:4]} + {1'b0, add_carry};
      add_sum[4*i+:4] = (dsum > 5'd9) ? 4'(dsum - 5'd10) : dsum[3:0];
      add_carry = {3'b0, dsum > 5'd9};
    end
  end
  // digit-serial subtract of the miss penalty; a final borrow means the result went negative
  always_comb begin
    sub_borrow = 4'(MISS_PENALTY);
    sub_diff = '0;
    ddiff = '0;
    lt = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      lt = score_bcd[4*i+:4] < sub_borrow;
      ddiff = lt ? score_bcd[4*i+:4] + 4'd10 - sub_borrow : score_bcd[4*i+:4] - sub_borrow;
      sub_diff[4*i+:4] = ddiff;
      sub_borrow = {3'b0, lt};
    end
  end
  assign score_next = clear ? '0
                    : hit ? ((add_carry != 4'd0) ? ALL_NINE : add_sum)
                    : miss ? ((sub_borrow != 4'd0) ? '0 : sub_diff)
                    : score_bcd;
  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    bcd_seg_decoder u_dec (.digit(score_bcd[4*i+:4]), .seg(seg_raw[7*i+:7]));
`ifdef SCORE_LEADING_ZERO_BLANK_EN
    assign seg_next[7*i+:7] = (i != 0 && score_bcd[W-1:4*i] == '0) ? SEG_BLANK : seg_raw[7*i+:7];
`else
    assign seg_next[7*i+:7] = seg_raw[7*i+:7];
`endif
  end
  // score, saturation flag and high-score tracking; high compares the already registered score
  always_ff @(posedge Clock) begin
    if (reset) begin
      score_bcd <= '0;
      high_bcd <= '0;
      new_high <= 1'b0;
      saturated <= 1'b0;
    end else begin
      score_bcd <= score_next;
      saturated <= score_next == ALL_NINE;
      new_high <= score_bcd > high_bcd;
      if (score_bcd > high_bcd) high_bcd <= score_bcd;
    end
  end
  // display register, one cycle behind the score
  always_ff @(posedge Clock) begin
    seg <= reset ? SEG_RESET : seg_next;
  end
endmodule

// File: tb/tb_bcd_score_display.sv
// tb_bcd_score_display: directed plus random checks against a decimal reference model
module tb_bcd_score_display;
  localparam int MAX2 = 99;
  localparam int PEN = 1;
  localparam logic [6:0] SEGS [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                       7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  logic Clock = 1'b0;
  always #5 Clock = ~Clock;
  logic reset, clear, hit, miss;
  logic [3:0] points;
  logic [7:0] score_bcd, high_bcd;
  logic [13:0] seg;
  logic new_high, saturated;
  logic reset4, hit4;
  logic clear4 = 1'b0;
  logic miss4 = 1'b0;
  logic [3:0] points4;
  logic [15:0] score4, high4;
  logic [27:0] seg4;
  logic new_high4, saturated4;
  int passed = 0, total = 0;
  int m_score = 0, m_high = 0, m_disp = 0;
  bit m_nh = 0, m_sat = 0;

  bcd_score_display #(.DIGITS(2), .MISS_PENALTY(PEN)) dut (
    .Clock(Clock), .reset(reset), .clear(clear), .hit(hit), .miss(miss), .points(points),
    .score_bcd(score_bcd), .high_bcd(high_bcd), .seg(seg), .new_high(new_high), .saturated(saturated));

  bcd_score_display #(.DIGITS(4), .MISS_PENALTY(1)) dut4 (
    .Clock(Clock), .reset(reset4), .clear(clear4), .hit(hit4), .miss(miss4), .points(points4),
    .score_bcd(score4), .high_bcd(high4), .seg(seg4), .new_high(new_high4), .saturated(saturated4));

  function automatic logic [63:0] to_bcd(int v, int n);
    logic [63:0] r = '0;
    int p = 1;
    for (int i = 0; i < n; i++) begin
      r[4*i+:4] = 4'((v / p) % 10);
      p *= 10;
    end
    return r;
  endfunction

  function automatic logic [63:0] to_seg(int v, int n);
    logic [63:0] r = '0;
    int p = 1;
    bit blank;
    for (int i = 0; i < n; i++) begin
      blank = 0;
`ifdef SCORE_LEADING_ZERO_BLANK_EN
      blank = (i > 0) && (v < p);
`endif
      r[7*i+:7] = blank ? 7'b1111111 : SEGS[(v / p) % 10];
      p *= 10;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input bit r, input bit c, input bit h, input bit m, input int p);
    int prev;
    reset = r; clear = c; hit = h; miss = m; points = 4'(p);
    @(posedge Clock);
    #1;
    prev = m_score;
    if (r) begin
      m_score = 0; m_high = 0; m_nh = 0; m_disp = 0; m_sat = 0;
    end else begin
      m_nh = prev > m_high;
      if (m_nh) m_high = prev;
      m_disp = prev;
      if (c) m_score = 0;
      else if (h) m_score = (prev + (p > 9 ? 9 : p) > MAX2) ? MAX2 : prev + (p > 9 ? 9 : p);
      else if (m) m_score = (prev - PEN < 0) ? 0 : prev - PEN;
      m_sat = m_score == MAX2;
    end
    check("score", 64'(score_bcd), to_bcd(m_score, 2));
    check("high", 64'(high_bcd), to_bcd(m_high, 2));
    check("new_high", 64'(new_high), 64'(m_nh));
    check("saturated", 64'(saturated), 64'(m_sat));
    check("seg", 64'(seg), to_seg(m_disp, 2));
    reset = 0; clear = 0; hit = 0; miss = 0; points = 0;
  endtask

  initial begin
    reset = 1; clear = 0; hit = 0; miss = 0; points = 0;
    reset4 = 1; hit4 = 0; points4 = 0;
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 5);
    step(0, 0, 1, 0, 7);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 5);
    step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (10) step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 14);
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 10);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 11);
    step(0, 0, 1, 0, 2);
    step(0, 0, 1, 1, 3);
    step(1, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 4);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (4) step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 2);
    step(0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 3);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    repeat (3) step(0, 0, 1, 0, 9);
    step(0, 0, 1, 0, 3);
    step(1, 0, 1, 0, 5);
    step(0, 0, 0, 0, 0);
    repeat (400)
      step(($urandom % 60) == 0, ($urandom % 30) == 0, ($urandom % 2) == 0, ($urandom % 3) == 0, int'($urandom % 16));
    reset4 = 0; hit4 = 1; points4 = 4'd9;
    repeat (111) @(posedge Clock);
    #1;
    check("d4_score_999", 64'(score4), 64'h0999);
    points4 = 4'd1;
    @(posedge Clock);
    #1;
    hit4 = 0;
    check("d4_score_1000", 64'(score4), 64'h1000);
    check("d4_saturated", 64'(saturated4), 64'd0);
    @(posedge Clock);
    #1;
    check("d4_high", 64'(high4), 64'h1000);
    check("d4_new_high", 64'(new_high4), 64'd1);
    check("d4_seg", 64'(seg4), to_seg(1000, 4));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
